// File: rtl/inst_fetch.sv
// Instruction-fetch stage: drives a 1-cycle synchronous ROM, buffers returned words
// in a small FIFO and hands them to IF/ID. Optional build macro: FETCH_ALIGN_CHECK_EN.
module inst_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        rom_ce_o,
  output logic [31:0] rom_addr_o,
  input  logic [31:0] rom_data_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        id_ready_i,
  output logic        if_valid_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o,
  output logic        if_adel_o
);
  localparam int unsigned   PW        = $clog2(FIFO_DEPTH);
  localparam int unsigned   CW        = $clog2(FIFO_DEPTH + 1);
  localparam logic [PW-1:0] LAST_SLOT = PW'(FIFO_DEPTH - 1);

  logic [31:0]   fifo_pc   [FIFO_DEPTH];
  logic [31:0]   fifo_inst [FIFO_DEPTH];
  logic          fifo_adel [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, cnt_next;

  logic [31:0] next_pc, rsp_pc;
  logic        rsp_v, halt;

  logic        push, pop, issue;
  logic [31:0] push_pc, push_inst;
  logic        push_adel;
  logic [31:0] redir_pc;
  logic        redir_bad;

`ifdef FETCH_ALIGN_CHECK_EN
  localparam logic [31:0] START_PC = RESET_PC;
  logic        err_v;
  logic [31:0] err_pc;

  assign redir_pc  = redirect_pc_i;
  assign redir_bad = |redirect_pc_i[1:0];

  // A redirect always clears rsp_v, so the error entry never collides with a ROM response
  always_comb begin
    push      = rsp_v | err_v;
    push_pc   = err_v ? err_pc : rsp_pc;
    push_inst = err_v ? '0 : rom_data_i;
    push_adel = err_v;
  end
`else
  localparam logic [31:0] START_PC = {RESET_PC[31:2], 2'b00};
  logic unused_redir_lo;

  assign unused_redir_lo = ^redirect_pc_i[1:0];
  assign redir_pc        = {redirect_pc_i[31:2], 2'b00};
  assign redir_bad       = 1'b0;

  always_comb begin
    push      = rsp_v;
    push_pc   = rsp_pc;
    push_inst = rom_data_i;
    push_adel = 1'b0;
  end
`endif

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_SLOT) ? '0 : p + PW'(1);
  endfunction

  assign if_valid_o = (count != '0);
  assign if_pc_o    = fifo_pc[rd_ptr];
  assign if_inst_o  = fifo_inst[rd_ptr];
  assign if_adel_o  = fifo_adel[rd_ptr];

  // Reserve a slot for the request already on the bus and the one about to issue,
  // since ROM responses cannot be back-pressured
  always_comb begin
    pop      = if_valid_o & id_ready_i;
    cnt_next = count + CW'(push) - CW'(pop);
    issue    = !halt && ((32'(cnt_next) + 32'(rom_ce_o) + 32'd1) <= FIFO_DEPTH);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rom_ce_o   <= 1'b0;
      rom_addr_o <= '0;
      next_pc    <= START_PC;
      rsp_v      <= 1'b0;
      rsp_pc     <= '0;
      halt       <= 1'b0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        fifo_pc[i]   <= '0;
        fifo_inst[i] <= '0;
        fifo_adel[i] <= 1'b0;
      end
`ifdef FETCH_ALIGN_CHECK_EN
      err_v      <= 1'b0;
      err_pc     <= '0;
`endif
    end else if (redirect_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      rsp_v  <= 1'b0;
      if (redir_bad) begin
        rom_ce_o <= 1'b0;
        halt     <= 1'b1;
      end else begin
        rom_ce_o   <= 1'b1;
        rom_addr_o <= redir_pc;
        next_pc    <= redir_pc + 32'd4;
        halt       <= 1'b0;
      end
`ifdef FETCH_ALIGN_CHECK_EN
      err_v  <= redir_bad;
      err_pc <= redirect_pc_i;
`endif
    end else begin
      rsp_v  <= rom_ce_o;
      rsp_pc <= rom_addr_o;
      if (push) begin
        fifo_pc[wr_ptr]   <= push_pc;
        fifo_inst[wr_ptr] <= push_inst;
        fifo_adel[wr_ptr] <= push_adel;
        wr_ptr            <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      count <= cnt_next;
      if (issue) begin
        rom_ce_o   <= 1'b1;
        rom_addr_o <= next_pc;
        next_pc    <= next_pc + 32'd4;
      end else begin
        rom_ce_o <= 1'b0;
      end
`ifdef FETCH_ALIGN_CHECK_EN
      err_v <= 1'b0;
`endif
    end
  end
endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed vector table, hand-written corner
// sequences and randomized traffic checked against a stream-level fetch model.
module tb_inst_fetch;
  logic        clk = 1'b0;
  logic        rst;
  logic        rom_ce_o;
  logic [31:0] rom_addr_o;
  logic [31:0] rom_data_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        id_ready_i;
  logic        if_valid_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;
  logic        if_adel_o;

  inst_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .rom_ce_o(rom_ce_o), .rom_addr_o(rom_addr_o), .rom_data_i(rom_data_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .id_ready_i(id_ready_i),
    .if_valid_o(if_valid_o), .if_pc_o(if_pc_o), .if_inst_o(if_inst_o), .if_adel_o(if_adel_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Synchronous ROM: word for the address presented in the previous cycle
  always @(posedge clk) rom_data_i <= rom_ce_o ? rom_word(rom_addr_o) : 32'hDEAD_BEEF;

  int unsigned tests = 0;
  int unsigned fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Stream model: expected PC of the next accepted instruction
  logic [31:0] m_pc;
  bit          m_err, m_dead;
  int unsigned n_acc;
  logic [31:0] first_pc, last_pc;

  task automatic model_redirect(input logic [31:0] t);
    m_dead = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    m_pc  = t;
    m_err = (t[1:0] != 2'b00);
`else
    m_pc  = t & 32'hFFFF_FFFC;
    m_err = 1'b0;
`endif
  endtask

  task automatic model_accept(input logic [31:0] p, input logic [31:0] i, input logic a);
    if (n_acc == 0) first_pc = p;
    n_acc++;
    last_pc = p;
    if (m_dead) begin
      check("fire_after_halt", 32'd1, 32'd0);
    end else if (m_err) begin
      check("adel_entry_pc", p, m_pc);
      check("adel_entry_inst", i, 32'h0);
      check("adel_entry_flag", 32'(a), 32'd1);
      m_err  = 1'b0;
      m_dead = 1'b1;
    end else begin
      check("stream_pc", p, m_pc);
      check("stream_inst", i, rom_word(p));
      check("stream_adel", 32'(a), 32'd0);
      m_pc = m_pc + 32'd4;
    end
  endtask

  // One clock: inputs already driven; sample handshake before the edge, outputs #1 after
  task automatic step();
    logic        fire, rst_s, red_s, a;
    logic [31:0] tgt_s, p, i;
    rst_s = rst;
    red_s = redirect_i;
    tgt_s = redirect_pc_i;
    fire  = rst && !redirect_i && if_valid_o && id_ready_i;
    p = if_pc_o;
    i = if_inst_o;
    a = if_adel_o;
    @(posedge clk);
    #1;
    if (!rst_s) begin
      m_pc = 32'h0; m_err = 1'b0; m_dead = 1'b0;
    end else if (red_s) begin
      model_redirect(tgt_s);
    end else if (fire) begin
      model_accept(p, i, a);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rom_ce"}, 32'(rom_ce_o), 32'd0);
    check({tag, "_rom_addr"}, rom_addr_o, 32'h0);
    check({tag, "_valid"}, 32'(if_valid_o), 32'd0);
    check({tag, "_pc"}, if_pc_o, 32'h0);
    check({tag, "_inst"}, if_inst_o, 32'h0);
    check({tag, "_adel"}, 32'(if_adel_o), 32'd0);
  endtask

  task automatic wait_first_fire(input logic [31:0] exp_pc, input string name);
    int unsigned k = 0;
    n_acc = 0;
    while (n_acc == 0 && k < 12) begin
      step();
      k++;
    end
    check({name, "_timeout"}, 32'(n_acc != 0), 32'd1);
    if (n_acc != 0) check({name, "_first_pc"}, first_pc, exp_pc);
  endtask

  typedef struct {
    logic [31:0] target;
    int unsigned stall;
    int unsigned take;
    logic [31:0] exp_first;
    logic [31:0] exp_last;
  } vec_t;

  vec_t vecs[$];

  task automatic run_vec(input vec_t v);
    id_ready_i    = (v.stall == 0);
    redirect_i    = 1'b1;
    redirect_pc_i = v.target;
    step();
    redirect_i = 1'b0;
    check("vec_rom_ce", 32'(rom_ce_o), 32'd1);
    check("vec_rom_addr", rom_addr_o, v.exp_first);
    check("vec_flush", 32'(if_valid_o), 32'd0);
    step();
    check("vec_valid_e1", 32'(if_valid_o), 32'd0);
    step();
    check("vec_valid_e2", 32'(if_valid_o), 32'd1);
    check("vec_head_pc", if_pc_o, v.exp_first);
    if (v.stall != 0) begin
      repeat (v.stall) step();
      check("vec_stall_ce", 32'(rom_ce_o), 32'd0);
      check("vec_stall_head", if_pc_o, v.exp_first);
      id_ready_i = 1'b1;
    end
    n_acc = 0;
    repeat (v.take) step();
    check("vec_take_count", 32'(n_acc), 32'(v.take));
    check("vec_last_pc", last_pc, v.exp_last);
  endtask

  initial begin
    vecs.push_back('{32'h0000_0100, 0,  4, 32'h0000_0100, 32'h0000_010C});
    vecs.push_back('{32'hFFFF_FFFC, 0,  3, 32'hFFFF_FFFC, 32'h0000_0004});
    vecs.push_back('{32'h0000_0040, 10, 8, 32'h0000_0040, 32'h0000_005C});
    vecs.push_back('{32'h1000_0000, 6,  5, 32'h1000_0000, 32'h1000_0010});
`ifndef FETCH_ALIGN_CHECK_EN
    vecs.push_back('{32'h0000_0102, 0,  3, 32'h0000_0100, 32'h0000_0108});
`endif

    rst = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0; id_ready_i = 1'b1;
    m_pc = 32'h0; m_err = 1'b0; m_dead = 1'b0; n_acc = 0; first_pc = '0; last_pc = '0;
    repeat (3) step();
    check_reset_outputs("reset");

    // Reset release and steady streaming
    rst = 1'b1;
    step();
    check("rel_rom_ce", 32'(rom_ce_o), 32'd1);
    check("rel_rom_addr", rom_addr_o, 32'h0);
    step();
    check("rel_valid_e1", 32'(if_valid_o), 32'd0);
    step();
    check("rel_valid_e2", 32'(if_valid_o), 32'd1);
    check("rel_head_pc", if_pc_o, 32'h0);
    check("rel_head_inst", if_inst_o, rom_word(32'h0));
    n_acc = 0;
    repeat (20) step();
    check("steady_count", 32'(n_acc), 32'd20);
    check("steady_last_pc", last_pc, 32'h4C);

    // Stall mid-stream
    id_ready_i = 1'b0;
    step();
    check("stall_head0", if_pc_o, 32'h50);
    repeat (9) step();
    check("stall_rom_ce", 32'(rom_ce_o), 32'd0);
    check("stall_valid", 32'(if_valid_o), 32'd1);
    check("stall_head", if_pc_o, 32'h50);
    id_ready_i = 1'b1;
    n_acc = 0;
    repeat (8) step();
    check("stall_release_count", 32'(n_acc), 32'd8);
    check("stall_release_last", last_pc, 32'h6C);

    foreach (vecs[k]) run_vec(vecs[k]);

    // Back-to-back redirects: only the last survives
    id_ready_i = 1'b1;
    redirect_i = 1'b1; redirect_pc_i = 32'h200; step();
    redirect_pc_i = 32'h300; step();
    redirect_i = 1'b0;
    check("b2b_rom_addr", rom_addr_o, 32'h300);
    wait_first_fire(32'h300, "b2b");

`ifdef FETCH_ALIGN_CHECK_EN
    begin
      int unsigned busy = 0;
      id_ready_i = 1'b0;
      redirect_i = 1'b1; redirect_pc_i = 32'h102; step();
      redirect_i = 1'b0;
      check("adel_no_req", 32'(rom_ce_o), 32'd0);
      check("adel_flush", 32'(if_valid_o), 32'd0);
      step();
      check("adel_valid", 32'(if_valid_o), 32'd1);
      check("adel_pc", if_pc_o, 32'h102);
      check("adel_inst", if_inst_o, 32'h0);
      check("adel_flag", 32'(if_adel_o), 32'd1);
      check("adel_halt_ce", 32'(rom_ce_o), 32'd0);
      id_ready_i = 1'b1;
      n_acc = 0;
      step();
      check("adel_pop", 32'(n_acc), 32'd1);
      repeat (6) begin
        step();
        if (rom_ce_o || if_valid_o) busy++;
      end
      check("adel_halted", 32'(busy), 32'd0);
      redirect_i = 1'b1; redirect_pc_i = 32'h180; step();
      redirect_i = 1'b0;
      check("adel_resume_ce", 32'(rom_ce_o), 32'd1);
      check("adel_resume_addr", rom_addr_o, 32'h180);
      wait_first_fire(32'h180, "adel_resume");
    end
`endif

    // Randomized traffic
    for (int c = 0; c < 800; c++) begin
      rst           = ($urandom_range(0, 199) != 0);
      id_ready_i    = ($urandom_range(0, 9) < 7);
      redirect_i    = ($urandom_range(0, 99) < 4);
      redirect_pc_i = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC))
                                                  : ($urandom & 32'hFFFF_FFFC);
`ifndef FETCH_ALIGN_CHECK_EN
      redirect_pc_i = redirect_pc_i | ($urandom & 32'h3);
`endif
      step();
    end
    rst = 1'b1; redirect_i = 1'b0; id_ready_i = 1'b1;
    redirect_i = 1'b1; redirect_pc_i = 32'h800; step();
    redirect_i = 1'b0;
    wait_first_fire(32'h800, "post_random");

    // Reset wins over a simultaneous redirect
    redirect_i = 1'b1; redirect_pc_i = 32'h500; rst = 1'b0;
    step();
    check_reset_outputs("mid_reset");
    rst = 1'b1; redirect_i = 1'b0;
    step();
    check("mid_rel_rom_ce", 32'(rom_ce_o), 32'd1);
    check("mid_rel_rom_addr", rom_addr_o, 32'h0);
    wait_first_fire(32'h0, "mid_rel");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
